// File: rtl/bank_timing_scheduler_pkg.sv
// Shared types and timing defaults for the per-bank command legality controller.
package MemoryController_Definitions;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } bank_cmd_t;

  typedef enum logic [1:0] {
    BANK_IDLE        = 2'd0,
    BANK_ACTIVATING  = 2'd1,
    BANK_ACTIVE      = 2'd2,
    BANK_PRECHARGING = 2'd3
  } bank_state_t;

  localparam int unsigned DEF_T_RCD = 4;
  localparam int unsigned DEF_T_RP  = 4;
  localparam int unsigned DEF_T_RAS = 10;
  localparam int unsigned DEF_T_WR  = 6;
  localparam int unsigned DEF_T_RTP = 3;
  localparam int unsigned ROW_W     = 16;

  localparam int unsigned TMR_W = 6;
  localparam logic [TMR_W-1:0] TMR_MAX = 6'd62;

  // A constraint of N cycles is loaded as N-1 so the dependent command lands at edge k+N.
  function automatic logic [TMR_W-1:0] tmr_load(input int unsigned cycles);
    if (cycles == 0) begin
      return '0;
    end else if (cycles - 1 > 62) begin
      return TMR_MAX;
    end else begin
      return TMR_W'(cycles - 1);
    end
  endfunction

endpackage

// File: rtl/bank_timing_scheduler_if.sv
// Command handshake and bank status between the rank scheduler and one bank controller.
interface bank_timing_scheduler_if
  import MemoryController_Definitions::*;
#(
  parameter int unsigned ROW_W = MemoryController_Definitions::ROW_W
);

  logic              cmd_valid;
  bank_cmd_t         cmd_type;
  logic [ROW_W-1:0]  cmd_row;
  logic              cmd_ready;
  logic              cmd_illegal;
  bank_state_t       bank_state;
  logic              row_open;
  logic [ROW_W-1:0]  open_row;

  modport master (
    output cmd_valid, cmd_type, cmd_row,
    input  cmd_ready, cmd_illegal, bank_state, row_open, open_row
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_row,
    output cmd_ready, cmd_illegal, bank_state, row_open, open_row
  );

endinterface

// File: rtl/bank_timing_scheduler_timer.sv
// 6-bit constraint timer: load wins over decrement, decrements to zero and saturates.
module bank_constraint_timer
  import MemoryController_Definitions::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired,
  output logic [TMR_W-1:0] count
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_en) begin
      count_d = (load_val > TMR_MAX) ? TMR_MAX : load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/bank_timing_scheduler.sv
// Per-bank FSM and command legality decode; grants ACT/RD/WR/PRE only when state and timers allow.
module bank_timing_scheduler
  import MemoryController_Definitions::*;
#(
  parameter int unsigned T_RCD = DEF_T_RCD,
  parameter int unsigned T_RP  = DEF_T_RP,
  parameter int unsigned T_RAS = DEF_T_RAS,
  parameter int unsigned T_WR  = DEF_T_WR,
  parameter int unsigned T_RTP = DEF_T_RTP,
  parameter int unsigned ROW_W = MemoryController_Definitions::ROW_W
)(
  input  logic clk,
  input  logic rst,
  bank_timing_scheduler_if.slave bus
);

  if (T_RCD < 1 || T_RCD > 63 || T_RP < 1 || T_RP > 63 || T_RAS < 1 || T_RAS > 63 ||
      T_WR < 1 || T_WR > 63 || T_RTP < 1 || T_RTP > 63) begin : g_bad_timing
    $error("bank_timing_scheduler: timing parameters must lie in 1..63");
  end

  localparam logic [TMR_W-1:0] L_RCD = tmr_load(T_RCD);
  localparam logic [TMR_W-1:0] L_RP  = tmr_load(T_RP);
  localparam logic [TMR_W-1:0] L_RAS = tmr_load(T_RAS);
  localparam logic [TMR_W-1:0] L_WR  = tmr_load(T_WR);
  localparam logic [TMR_W-1:0] L_RTP = tmr_load(T_RTP);

  bank_state_t      state_q, state_d;
  logic [ROW_W-1:0] open_row_q, open_row_d;
  logic             illegal_q, illegal_d;

  logic             rcd_ld, rp_ld, ras_ld, pre_ld;
  logic [TMR_W-1:0] pre_ld_val, pre_dec;
  logic             rcd_exp, rp_exp, ras_exp, pre_exp;
  logic [TMR_W-1:0] rcd_cnt, rp_cnt, ras_cnt, pre_cnt;
  logic             unused_ras_cnt;

  logic ready_raw, never_legal, accept;

  bank_constraint_timer u_rcd (.clk(clk), .rst(rst), .load_en(rcd_ld), .load_val(L_RCD),
                               .expired(rcd_exp), .count(rcd_cnt));
  bank_constraint_timer u_rp  (.clk(clk), .rst(rst), .load_en(rp_ld),  .load_val(L_RP),
                               .expired(rp_exp),  .count(rp_cnt));
  bank_constraint_timer u_ras (.clk(clk), .rst(rst), .load_en(ras_ld), .load_val(L_RAS),
                               .expired(ras_exp), .count(ras_cnt));
  bank_constraint_timer u_pre (.clk(clk), .rst(rst), .load_en(pre_ld), .load_val(pre_ld_val),
                               .expired(pre_exp), .count(pre_cnt));

  assign unused_ras_cnt = ^ras_cnt;

  // Legality depends only on registered state and timers, never on cmd_valid.
  always_comb begin
    ready_raw   = 1'b0;
    never_legal = 1'b0;
    unique case (state_q)
      BANK_IDLE: begin
        if (bus.cmd_type == CMD_ACT) ready_raw = rp_exp;
        else                         never_legal = 1'b1;
      end
      BANK_ACTIVATING: begin
        if (bus.cmd_type == CMD_ACT || bus.cmd_type == CMD_PRE) never_legal = 1'b1;
      end
      BANK_ACTIVE: begin
        unique case (bus.cmd_type)
          CMD_ACT:        never_legal = 1'b1;
          CMD_RD, CMD_WR: ready_raw   = 1'b1;
          CMD_PRE:        ready_raw   = ras_exp & pre_exp;
          default:        never_legal = 1'b1;
        endcase
      end
      BANK_PRECHARGING: never_legal = 1'b1;
      default:          never_legal = 1'b1;
    endcase
  end

  assign bus.cmd_ready = ready_raw & rst;
  assign accept        = bus.cmd_valid & bus.cmd_ready;

  // Merge against the value pre_timer would reach this edge, so a later RD/WR never adds a cycle.
  assign pre_dec = pre_exp ? '0 : (pre_cnt - 6'd1);

  always_comb begin
    state_d    = state_q;
    open_row_d = open_row_q;
    illegal_d  = bus.cmd_valid & never_legal;
    rcd_ld     = 1'b0;
    rp_ld      = 1'b0;
    ras_ld     = 1'b0;
    pre_ld     = 1'b0;
    pre_ld_val = pre_dec;
    unique case (state_q)
      BANK_IDLE: begin
        if (accept) begin
          rcd_ld     = 1'b1;
          ras_ld     = 1'b1;
          open_row_d = bus.cmd_row;
          state_d    = (L_RCD == '0) ? BANK_ACTIVE : BANK_ACTIVATING;
        end
      end
      BANK_ACTIVATING: begin
        if (rcd_exp || rcd_cnt == 6'd1) state_d = BANK_ACTIVE;
      end
      BANK_ACTIVE: begin
        if (accept) begin
          unique case (bus.cmd_type)
            CMD_RD: begin
              pre_ld     = 1'b1;
              pre_ld_val = (pre_dec > L_RTP) ? pre_dec : L_RTP;
            end
            CMD_WR: begin
              pre_ld     = 1'b1;
              pre_ld_val = (pre_dec > L_WR) ? pre_dec : L_WR;
            end
            CMD_PRE: begin
              rp_ld   = 1'b1;
              state_d = (L_RP == '0) ? BANK_IDLE : BANK_PRECHARGING;
            end
            default: ;
          endcase
        end
      end
      BANK_PRECHARGING: begin
        if (rp_exp || rp_cnt == 6'd1) state_d = BANK_IDLE;
      end
      default: state_d = BANK_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BANK_IDLE;
      open_row_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      open_row_q <= open_row_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.bank_state  = state_q;
  assign bus.open_row    = open_row_q;
  assign bus.cmd_illegal = illegal_q;
  assign bus.row_open    = (state_q == BANK_ACTIVATING) || (state_q == BANK_ACTIVE);

`ifdef ASSERTION
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (bus.cmd_valid && !bus.cmd_ready) |=> (!bus.cmd_valid || bus.cmd_type == $past(bus.cmd_type)));
  a_accept_legal: assert property (@(posedge clk) disable iff (!rst)
    (bus.cmd_valid && bus.cmd_ready) |-> !never_legal);
`endif

endmodule

// File: tb/tb_bank_timing_scheduler.sv
// Bench for bank_timing_scheduler: absolute-cycle reference model, directed scenarios, random traffic.
module tb_bank_timing_scheduler;
  import MemoryController_Definitions::*;

  localparam int TRCD = 4, TRP = 4, TRAS = 10, TWR = 6, TRTP = 3;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bank_timing_scheduler_if #(.ROW_W(RW)) bus ();

  bank_timing_scheduler #(
    .T_RCD(TRCD), .T_RP(TRP), .T_RAS(TRAS), .T_WR(TWR), .T_RTP(TRTP), .ROW_W(RW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: remembers when the row was opened/closed and the earliest legal PRE, in absolute cycles.
  bit          m_open;
  int          m_act_at, m_pre_at, m_pre_ok;
  logic [RW-1:0] m_row;
  bit          m_ill_next;

  task automatic model_reset();
    m_open = 0; m_act_at = -1000; m_pre_at = -1000; m_pre_ok = 0;
    m_row = '0; m_ill_next = 0;
  endtask

  function automatic int m_state(input int c);
    if (m_open) return (c < m_act_at + TRCD) ? 1 : 2;
    return (c < m_pre_at + TRP) ? 3 : 0;
  endfunction

  function automatic bit m_ready(input int c, input int t);
    int s = m_state(c);
    if (t == 0) return s == 0;
    if (t == 1 || t == 2) return s == 2;
    return (s == 2) && (c >= m_pre_ok);
  endfunction

  function automatic bit m_never(input int c, input int t);
    int s = m_state(c);
    case (s)
      0: return t != 0;
      1: return (t == 0) || (t == 3);
      2: return t == 0;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int need);
    n_cmp++;
    if (got != need) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, need %0h", name, cyc, got, need);
    end
  endtask

  // One clock cycle: drive, compare all outputs with the model, advance the model, step the clock.
  task automatic cycle(input bit v, input int t, input logic [RW-1:0] row, output bit acc);
    int s;
    bus.cmd_valid = v;
    bus.cmd_type  = bank_cmd_t'(t[1:0]);
    bus.cmd_row   = row;
    #1;
    s = m_state(cyc);
    chk("bank_state", int'(bus.bank_state), s);
    chk("row_open", int'(bus.row_open), int'(s == 1 || s == 2));
    chk("open_row", int'(bus.open_row), int'(m_row));
    chk("cmd_illegal", int'(bus.cmd_illegal), int'(m_ill_next));
    chk("cmd_ready", int'(bus.cmd_ready), int'(m_ready(cyc, t)));
    acc = v && m_ready(cyc, t);
    m_ill_next = v && m_never(cyc, t);
    if (acc) begin
      case (t)
        0: begin m_open = 1; m_act_at = cyc; m_pre_ok = cyc + TRAS; m_row = row; end
        1: if (cyc + TRTP > m_pre_ok) m_pre_ok = cyc + TRTP;
        2: if (cyc + TWR > m_pre_ok) m_pre_ok = cyc + TWR;
        default: begin m_open = 0; m_pre_at = cyc; end
      endcase
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic hold(input int t, input logic [RW-1:0] row, output int at);
    bit acc = 0;
    at = -1;
    for (int n = 0; n < 64 && !acc; n++) begin
      cycle(1, t, row, acc);
      if (acc) at = cyc - 1;
    end
    if (!acc) chk("hold_timeout", 0, 1);
  endtask

  task automatic idle_until(input int c);
    bit acc;
    for (int n = 0; n < 200 && cyc < c; n++) cycle(0, 0, '0, acc);
  endtask

  task automatic do_reset();
    bus.cmd_valid = 0;
    bus.cmd_type  = CMD_ACT;
    bus.cmd_row   = '0;
    rst = 0;
    #1;
    model_reset();
    chk("rst_state", int'(bus.bank_state), 0);
    chk("rst_ready", int'(bus.cmd_ready), 0);
    chk("rst_illegal", int'(bus.cmd_illegal), 0);
    chk("rst_row_open", int'(bus.row_open), 0);
    chk("rst_open_row", int'(bus.open_row), 0);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1;
  endtask

  initial begin
    int a, t, p;
    bit acc, hv, v, nev;
    int ht;
    logic [RW-1:0] hrow;

    @(posedge clk);
    #1;
    do_reset();

    // Basic ACT -> RD
    hold(0, 16'h1234, a);
    hold(1, '0, t);
    chk("s1_rd_accept_offset", t - a, 4);
    chk("s1_open_row", int'(bus.open_row), 16'h1234);
    // tRAS dominates PRE, then tRP before next ACT
    hold(3, '0, t);
    chk("s2_pre_accept_offset", t - a, 10);
    hold(0, 16'h0042, t);
    chk("s2_act_accept_offset", t - a, 14);

    // Write recovery dominates
    a = t;
    idle_until(a + 8);
    cycle(1, 2, '0, acc);
    chk("s3_wr_at_8", int'(acc), 1);
    hold(3, '0, t);
    chk("s3_pre_accept_offset", t - a, 14);

    // Max-merge: RD after WR must not shorten recovery
    hold(0, 16'hbeef, a);
    idle_until(a + 8);
    cycle(1, 2, '0, acc);
    cycle(1, 1, '0, acc);
    chk("s4_rd_at_9", int'(acc), 1);
    hold(3, '0, t);
    chk("s4_pre_accept_offset", t - a, 14);

    // RD in IDLE is illegal
    idle_until(t + 6);
    cycle(1, 1, '0, acc);
    chk("s5_rd_ready", int'(bus.cmd_ready), 0);
    chk("s5_illegal_pulse", int'(bus.cmd_illegal), 1);
    chk("s5_state_idle", int'(bus.bank_state), 0);
    cycle(0, 0, '0, acc);
    chk("s5_illegal_one_cycle", int'(bus.cmd_illegal), 0);

    // Reset in the middle of precharging
    hold(0, 16'h5a5a, a);
    hold(3, '0, p);
    cycle(0, 0, '0, acc);
    chk("s6_precharging", int'(bus.bank_state), 3);
    do_reset();
    bus.cmd_type = CMD_ACT;
    #1;
    chk("s6_act_ready_after_reset", int'(bus.cmd_ready), 1);
    cycle(1, 0, 16'h0777, acc);
    chk("s6_act_accepted", int'(acc), 1);

    // Random traffic; a timing-blocked command is held until granted
    hv = 0; ht = 0; hrow = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        hv = 0;
      end
      if (hv) begin
        v = 1;
      end else begin
        v    = ($urandom_range(0, 9) < 6);
        ht   = $urandom_range(0, 3);
        hrow = RW'($urandom);
      end
      nev = m_never(cyc, ht);
      cycle(v, ht, hrow, acc);
      hv = v && !acc && !nev;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout @cyc %0d: got running, need finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
